muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide controller beside the execute-stage ALU. Accepts MULT/MULTU/DIV/DIVU ops,
//  runs a 1-bit-per-cycle shift-add / restoring-divide datapath, and holds the HI/LO result registers.
//  While busy it drives stall_req, so fetch/decode/execute freeze until the result is ready.
// PARAMETERS
//  WIDTH      32   operand width; HI and LO are each WIDTH bits
//  CNT_W       6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high; clears all state
//  req_valid  in   1        execute stage presents a mul/div op
//  req_op     in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data    in   WIDTH    multiplicand / dividend
//  rt_data    in   WIDTH    multiplier / divisor
//  req_ready  out  1        high only in IDLE; handshake completes on req_valid & req_ready
//  flush      in   1        branch squash; aborts the op in flight
//  stall_req  out  1        high in RUN and FIX; pipeline hold request
//  done       out  1        one-cycle pulse; hi_out/lo_out are updated in the same cycle
//  unsupported out 1        one-cycle pulse for a DIV op when division is compiled out
//  hi_out     out  WIDTH    HI register (mul upper half / div remainder)
//  lo_out     out  WIDTH    LO register (mul lower half / div quotient)
// BEHAVIOUR
//  Reset: state=IDLE, hi_out=lo_out=0, done=unsupported=stall_req=0, req_ready=1, counter=0.
//  FSM:
//   IDLE -> RUN on the handshake. Latch |rs| and |rt| (signed ops) or the raw operands (unsigned ops).
//     Latch sign_q = rs[msb]^rt[msb] and sign_r = rs[msb]. counter=0.
//   RUN: one step per cycle; counter++. After WIDTH steps (counter==WIDTH-1 at the edge) -> FIX.
//   FIX: apply two's-complement negation per sign_q/sign_r; write hi_out/lo_out; done=1 -> IDLE.
//  Latency: handshake edge at cycle 0; done is high during cycle WIDTH+1 (33 cycles at the default).
//   A new request may be accepted on the cycle done is high (state is IDLE then).
//  Arithmetic:
//   - MUL: 2*WIDTH-bit product; HI = upper half, LO = lower half.
//   - DIV: LO = quotient truncated toward zero; remainder takes the dividend's sign.
//  Boundaries:
//   - Divide by zero: no exception; HI = rs_data, LO = all ones (raw iteration result, no sign fix).
//   - DIV of -2**(WIDTH-1) by -1: LO = 0x8000_0000, HI = 0.
//   - Operand 0x8000_0000 in MULT: the absolute value is handled as unsigned WIDTH bits, so the product
//     is correct (e.g. -2^31 * -2^31 -> HI=0x4000_0000, LO=0).
//   - req_valid outside IDLE is ignored (req_ready=0); the requester holds it.
//  Flush:
//   - In RUN or FIX: go to IDLE next edge; hi_out/lo_out unchanged; no done.
//   - Together with a handshake in IDLE: flush wins; the request is dropped.
//  Reset mid-op: immediate return to IDLE with the reset values; the partial result is discarded.
// CONFIGURATION
//  MULDIV_DIV_EN
//   - defined: all four ops as above.
//   - undefined: divider logic is removed. A DIV/DIVU handshake goes IDLE -> FIX with no RUN,
//     pulses unsupported (not done) on the next cycle, and leaves hi_out/lo_out unchanged.
//     stall_req stays 0.
// STRUCTURE
//  Shared package muldiv_pkg: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and
//  state encodings (MD_IDLE, MD_RUN, MD_FIX); add to control.vh/functions.vh-style includes.
//  Sub-module muldiv_step: combinational single iteration. Inputs: partial {hi,lo}, operand, mode.
//  Outputs: next {hi,lo} (add-shift for mul, trial-subtract-shift for div). Instantiated once.
// TESTING
//  1. MULTU 0xFFFF_FFFF x 2 -> done at cycle 33, HI=0x0000_0001, LO=0xFFFF_FFFE; stall_req high cycles 1-32.
//  2. MULT -3 x 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
//  3. DIV -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); DIVU 100/7 -> LO=14, HI=2.
//  4. DIVU 5 / 0 -> LO=0xFFFF_FFFF, HI=5, done pulses, no hang.
//  5. Start MULT 6x7; flush at cycle 10 -> IDLE at cycle 11, no done, HI/LO hold prior values.
//     Back-to-back request accepted in the done cycle completes 33 cycles later.
//  6. Assert reset at cycle 5 of a DIV -> outputs at reset values immediately; with MULDIV_DIV_EN
//     undefined, DIV 9/3 -> unsupported pulse at cycle 1, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   md_op_e    : request opcode encodings as presented on req_op
//   md_state_e : sequencer state encodings
// Optional feature macro used by the files importing this package:
//   MULDIV_DIV_EN - when defined, DIV/DIVU are executed; otherwise they are
//                   rejected with an 'unsupported' pulse.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   hi_i, lo_i : partial accumulator {hi,lo}
//   operand_i  : multiplicand (mul) or divisor (div), unsigned
//   is_div_i   : selects trial-subtract-shift (present only with MULDIV_DIV_EN)
//   hi_o, lo_o : accumulator after this iteration
// Mul: add operand into hi when lo[0] is set, then shift {carry,hi,lo} right.
// Div: shift {hi,lo} left, trial-subtract operand from the upper part and
//      shift in the quotient bit. Removed entirely without MULDIV_DIV_EN.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] operand_i,
`ifdef MULDIV_DIV_EN
  input  logic             is_div_i,
`endif
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
`endif

  always_comb begin
    mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
    hi_o    = mul_sum[WIDTH:1];
    lo_o    = {mul_sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh   = {hi_i, lo_i[WIDTH-1]};
    // When the trial subtract succeeds the true difference is below the
    // divisor, so its low WIDTH bits are exact.
    rem_diff = rem_sh[WIDTH-1:0] - operand_i;
    if (is_div_i) begin
      if (rem_sh >= {1'b0, operand_i}) begin
        hi_o = rem_diff;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide controller with HI/LO result registers.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   req_valid/req_op  : op request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_data, rt_data  : multiplicand/dividend, multiplier/divisor
//   req_ready         : high only while idle
//   flush             : aborts the op in flight, drops a same-cycle request
//   stall_req         : pipeline hold while an op is executing
//   done              : one-cycle pulse, hi_out/lo_out updated that cycle
//   unsupported       : one-cycle pulse for DIV/DIVU when division is absent
//   hi_out, lo_out    : HI/LO result registers
// Macro MULDIV_DIV_EN enables the divider; undefined, DIV/DIVU are rejected.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             req_ready,
  input  logic             flush,
  output logic             stall_req,
  output logic             done,
  output logic             unsupported,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // The first iteration runs on the accepting edge, so RUN lasts WIDTH-1
  // cycles and FIX still completes with done in cycle WIDTH+1.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             sign_n_q, sign_n_d;
  logic             ready_q, ready_d, stall_q, stall_d;
  logic             done_q, done_d, unsup_q, unsup_d;
`ifdef MULDIV_DIV_EN
  logic             sign_r_q, sign_r_d;
  logic             dvz_q, dvz_d;
`endif

  md_op_e           op_e;
  logic             req_div, req_signed;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH-1:0] step_hi_in, step_lo_in, step_opnd;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    op_e       = md_op_e'(req_op);
    req_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
    req_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    abs_rs     = (req_signed && rs_data[WIDTH-1]) ? ('0 - rs_data) : rs_data;
    abs_rt     = (req_signed && rt_data[WIDTH-1]) ? ('0 - rt_data) : rt_data;
    if (state_q == MD_IDLE) begin
      step_hi_in = '0;
`ifdef MULDIV_DIV_EN
      step_lo_in = req_div ? abs_rs : abs_rt;
      step_opnd  = req_div ? abs_rt : abs_rs;
`else
      step_lo_in = abs_rt;
      step_opnd  = abs_rs;
`endif
    end else begin
      step_hi_in = acc_hi_q;
      step_lo_in = acc_lo_q;
      step_opnd  = opnd_q;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .hi_i      (step_hi_in),
    .lo_i      (step_lo_in),
    .operand_i (step_opnd),
`ifdef MULDIV_DIV_EN
    .is_div_i  ((state_q == MD_IDLE) ? req_div : is_div_q),
`endif
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sign_n_d = sign_n_q;
    done_d   = 1'b0;
    unsup_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    sign_r_d = sign_r_q;
    dvz_d    = dvz_q;
`endif
    prod     = {acc_hi_q, acc_lo_q};
    prod_neg = '0 - prod;

    case (state_q)
      MD_IDLE: begin
        if (!flush && req_valid) begin
          is_div_d = req_div;
`ifndef MULDIV_DIV_EN
          if (req_div) begin
            unsup_d = 1'b1;
            state_d = MD_FIX;
          end else begin
`else
          begin
            sign_r_d = req_signed & rs_data[WIDTH-1];
            dvz_d    = (rt_data == '0);
`endif
            opnd_d   = step_opnd;
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            sign_n_d = req_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            cnt_d    = '0;
            state_d  = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!flush) begin
          if (!is_div_q) begin
            {hi_d, lo_d} = sign_n_q ? prod_neg : prod;
            done_d       = 1'b1;
          end
`ifdef MULDIV_DIV_EN
          else begin
            // Divide by zero keeps the raw all-ones quotient; the remainder
            // sign fix still restores HI to the original dividend.
            lo_d   = (sign_n_q && !dvz_q) ? ('0 - acc_lo_q) : acc_lo_q;
            hi_d   = sign_r_q ? ('0 - acc_hi_q) : acc_hi_q;
            done_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = MD_IDLE;
    endcase

    ready_d = (state_d == MD_IDLE);
    stall_d = (state_d == MD_RUN) || ((state_d == MD_FIX) && !unsup_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_n_q <= 1'b0;
      ready_q  <= 1'b1;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
      unsup_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      sign_r_q <= 1'b0;
      dvz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sign_n_q <= sign_n_d;
      ready_q  <= ready_d;
      stall_q  <= stall_d;
      done_q   <= done_d;
      unsup_q  <= unsup_d;
`ifdef MULDIV_DIV_EN
      sign_r_q <= sign_r_d;
      dvz_q    <= dvz_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign stall_req   = stall_q;
  assign done        = done_q;
  assign unsupported = unsup_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clock, reset, req_valid, flush;
  logic [1:0]   req_op;
  logic [W-1:0] rs_data, rt_data;
  logic         req_ready, stall_req, done, unsupported;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl_hi, mdl_lo;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs, rt, hi, lo;
  } vec_t;
  vec_t vecs[16];

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .req_ready   (req_ready),
    .flush       (flush),
    .stall_req   (stall_req),
    .done        (done),
    .unsupported (unsupported),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    rs_data   = a;
    rt_data   = b;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Issue a vector and follow it to its done/unsupported cycle. Returns at the
  // negedge of that cycle, so a following call is a back-to-back request.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, stalls, done_cyc, unsup_cyc;
    chk($sformatf("v%0d_ready_pre", idx), {31'b0, req_ready}, 32'd1);
    start_op(v.op, v.rs, v.rt);
    cyc = 1; stalls = 0; done_cyc = 0; unsup_cyc = 0;
    while (cyc <= 40 && done_cyc == 0 && unsup_cyc == 0) begin
      if (stall_req)   stalls++;
      if (done)        done_cyc = cyc;
      if (unsupported) unsup_cyc = cyc;
      if (done_cyc == 0 && unsup_cyc == 0) begin
        @(negedge clock);
        cyc++;
      end
    end
    if (v.op[1] && !DIV_EN) begin
      chk($sformatf("v%0d_unsup_cyc", idx), unsup_cyc, 1);
      chk($sformatf("v%0d_done_cyc", idx), done_cyc, 0);
      chk($sformatf("v%0d_stalls", idx), stalls, 0);
      chk($sformatf("v%0d_hi_hold", idx), hi_out, mdl_hi);
      chk($sformatf("v%0d_lo_hold", idx), lo_out, mdl_lo);
      @(negedge clock);
      chk($sformatf("v%0d_unsup_pulse", idx), {31'b0, unsupported}, 32'd0);
      chk($sformatf("v%0d_no_done", idx), {31'b0, done}, 32'd0);
    end else begin
      chk($sformatf("v%0d_done_cyc", idx), done_cyc, 33);
      chk($sformatf("v%0d_unsup_cyc", idx), unsup_cyc, 0);
      chk($sformatf("v%0d_stalls", idx), stalls, 32);
      chk($sformatf("v%0d_hi", idx), hi_out, v.hi);
      chk($sformatf("v%0d_lo", idx), lo_out, v.lo);
      mdl_hi = v.hi;
      mdl_lo = v.lo;
    end
  endtask

  initial begin
    int ndone;
    vec_t v;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{2'b10, 32'd9,         32'd3,         32'd0,         32'd3};
    vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[10] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[11] = '{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[12] = '{2'b11, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF};
    vecs[13] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[14] = '{2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
    vecs[15] = '{2'b01, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; flush = 1'b0;
    rs_data = '0; rt_data = '0;
    mdl_hi = '0; mdl_lo = '0;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_unsup", {31'b0, unsupported}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Flush during RUN at cycle 10: idle at cycle 11, no done, HI/LO held.
    @(negedge clock);
    start_op(2'b00, 32'd6, 32'd7);
    ndone = 0;
    for (int c = 2; c <= 10; c++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_stall", {31'b0, stall_req}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_hi_hold", hi_out, mdl_hi);
    chk("flush_lo_hold", lo_out, mdl_lo);

    // Flush together with a handshake: the request is dropped.
    req_valid = 1'b1; req_op = 2'b01; rs_data = 32'd2; rt_data = 32'd2;
    flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    chk("flhs_ready", {31'b0, req_ready}, 32'd1);
    chk("flhs_stall", {31'b0, stall_req}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    chk("flhs_no_done", ndone, 0);
    chk("flhs_hi_hold", hi_out, mdl_hi);

    // Load a nonzero result, then reset at cycle 5 of a following op.
    v = '{2'b01, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001};
    run_vec(16, v);
    if (DIV_EN) start_op(2'b11, 32'd100, 32'd7);
    else        start_op(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mrst_hi", hi_out, 32'd0);
    chk("mrst_lo", lo_out, 32'd0);
    chk("mrst_ready", {31'b0, req_ready}, 32'd1);
    chk("mrst_stall", {31'b0, stall_req}, 32'd0);
    chk("mrst_done", {31'b0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clock);
    v = '{2'b00, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    run_vec(17, v);
    v = '{2'b10, 32'd9, 32'd3, 32'd0, 32'd3};
    run_vec(18, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
